// File: rtl/rgb_colour_sequencer_pkg.sv
// Shared types and helpers for the RGB matrix colour sequencer.
package rgb_matrix_pkg;

  typedef enum logic [2:0] {
    RED     = 3'd0,
    GREEN   = 3'd1,
    BLUE    = 3'd2,
    CYAN    = 3'd3,
    MAGENTA = 3'd4,
    YELLOW  = 3'd5,
    BLACK   = 3'd6
  } colour_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic LED_OFF = 1'b1;

  // {r,g,b} enables; the unused code 7 maps to all-off
  function automatic logic [2:0] colour_mask(colour_t c);
    case (c)
      RED:     colour_mask = 3'b100;
      GREEN:   colour_mask = 3'b010;
      BLUE:    colour_mask = 3'b001;
      CYAN:    colour_mask = 3'b011;
      MAGENTA: colour_mask = 3'b101;
      YELLOW:  colour_mask = 3'b110;
      default: colour_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rgb_colour_sequencer_if.sv
// Board-side signal bundle: raw button in, LED cathode buses and status out.
interface rgb_colour_sequencer_if #(
  parameter int unsigned N_LEDS = 25
);
  logic              button;
  logic [N_LEDS-1:0] R;
  logic [N_LEDS-1:0] G;
  logic [N_LEDS-1:0] B;
  logic [2:0]        colour;
  logic              btn_evt;

  modport master (output button, input R, G, B, colour, btn_evt);
  modport slave  (input button, output R, G, B, colour, btn_evt);
endinterface

// File: rtl/rgb_colour_sequencer_button_debouncer.sv
// Synchronises an active-low push-button, debounces it and emits one pulse per press.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic button_n,
  output logic pressed_pulse
);
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= button_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = ~level_q;
      // only the released->pressed transition counts as a press
      pulse_d = level_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign pressed_pulse = pulse_q;

endmodule

// File: rtl/rgb_colour_sequencer.sv
// Colour sequencer: steps a fixed colour list on timer or button press and
// drives the active-low LED buses with a breathing PWM envelope.
module rgb_colour_sequencer
  import rgb_matrix_pkg::*;
#(
  parameter int unsigned N_LEDS          = 25,
  parameter int unsigned PWM_PERIOD      = 5000,
  parameter int unsigned DUTY_MAX        = 4000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic                  clk,
  input  logic                  rst,
  rgb_colour_sequencer_if.slave led_if
);
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned PWM_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PWM_W-1:0]  PWM_LAST  = PWM_W'(PWM_PERIOD - 1);
  localparam logic [PWM_W-1:0]  DUTY_TOP  = PWM_W'(DUTY_MAX);

  colour_t           colour_q, colour_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0]  duty_q, duty_d;
  dir_t              dir_q, dir_d;
  logic [N_LEDS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic       btn_evt;
  logic       advance;
  logic       pwm_wrap;
  logic       pwm_on;
  logic [2:0] mask;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk          (clk),
    .rst          (rst),
    .button_n     (led_if.button),
    .pressed_pulse(btn_evt)
  );

  assign advance  = (hold_cnt_q == HOLD_LAST) || btn_evt;
  assign pwm_wrap = (pwm_cnt_q == PWM_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      colour_q   <= RED;
      hold_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
      dir_q      <= DIR_UP;
      r_q        <= {N_LEDS{LED_OFF}};
      g_q        <= {N_LEDS{LED_OFF}};
      b_q        <= {N_LEDS{LED_OFF}};
    end else begin
      colour_q   <= colour_d;
      hold_cnt_q <= hold_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
    end
  end

  // Illegal code 7 falls into default and recovers to RED unconditionally
  always_comb begin
    colour_d = colour_q;
    case (colour_q)
      RED:     colour_d = advance ? GREEN   : RED;
      GREEN:   colour_d = advance ? BLUE    : GREEN;
      BLUE:    colour_d = advance ? CYAN    : BLUE;
      CYAN:    colour_d = advance ? MAGENTA : CYAN;
      MAGENTA: colour_d = advance ? YELLOW  : MAGENTA;
      YELLOW:  colour_d = advance ? BLACK   : YELLOW;
      BLACK:   colour_d = advance ? RED     : BLACK;
      default: colour_d = RED;
    endcase
  end

  always_comb begin
    hold_cnt_d = advance ? '0 : hold_cnt_q + 1'b1;
    pwm_cnt_d  = pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
    duty_d     = duty_q;
    dir_d      = dir_q;
    if (pwm_wrap) begin
      if (dir_q == DIR_UP) begin
        if (duty_q == DUTY_TOP) begin
          dir_d  = DIR_DOWN;
          duty_d = duty_q - 1'b1;
        end else begin
          duty_d = duty_q + 1'b1;
        end
      end else begin
        if (duty_q == '0) begin
          dir_d  = DIR_UP;
          duty_d = duty_q + 1'b1;
        end else begin
          duty_d = duty_q - 1'b1;
        end
      end
    end
  end

  always_comb begin
    mask   = colour_mask(colour_q);
    pwm_on = (pwm_cnt_q < duty_q);
    r_d    = {N_LEDS{~(mask[2] & pwm_on)}};
    g_d    = {N_LEDS{~(mask[1] & pwm_on)}};
    b_d    = {N_LEDS{~(mask[0] & pwm_on)}};
  end

  assign led_if.R       = r_q;
  assign led_if.G       = g_q;
  assign led_if.B       = b_q;
  assign led_if.colour  = colour_q;
  assign led_if.btn_evt = btn_evt;

endmodule

// File: tb/tb_rgb_colour_sequencer.sv
// Directed bench for rgb_colour_sequencer with small timing parameters.
module tb_rgb_colour_sequencer;
  localparam int unsigned N = 4;

  typedef struct {
    int unsigned n;
    logic [2:0]  colour;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;
  vec_t        vecs[17];
  int unsigned exp_frame[30];

  always #5 clk = ~clk;

  rgb_colour_sequencer_if #(.N_LEDS(N)) led_if ();

  rgb_colour_sequencer #(
    .N_LEDS         (N),
    .PWM_PERIOD     (10),
    .DUTY_MAX       (8),
    .HOLD_CYCLES    (20),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .led_if(led_if)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_rgb(input string name, input logic [2:0] col,
                         input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    chk({name, "_colour"}, 32'(led_if.colour), 32'(col));
    chk({name, "_R"}, 32'(led_if.R), 32'(r));
    chk({name, "_G"}, 32'(led_if.G), 32'(g));
    chk({name, "_B"}, 32'(led_if.B), 32'(b));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    led_if.button = 1'b1;
    tick();
    tick();
    chk_rgb("reset", 3'd0, 4'hF, 4'hF, 4'hF);
    chk("reset_btn_evt", 32'(led_if.btn_evt), 0);
    rst = 1'b0;
  endtask

  // n = index of the post-reset edge just sampled
  task automatic run_auto(input int unsigned cycles);
    int unsigned r_lo, g_lo, b_lo, any_lo;
    r_lo = 0; g_lo = 0; b_lo = 0; any_lo = 0;
    for (int unsigned n = 0; n < cycles; n++) begin
      tick();
      chk("colour_legal", 32'(led_if.colour == 3'd7), 0);
      for (int v = 0; v < 17; v++)
        if (vecs[v].n == n)
          chk_rgb($sformatf("auto_n%0d", n), vecs[v].colour, vecs[v].r, vecs[v].g, vecs[v].b);
      if (led_if.R[0] == 1'b0) r_lo++;
      if (led_if.G[0] == 1'b0) g_lo++;
      if (led_if.B[0] == 1'b0) b_lo++;
      if ((led_if.R[0] & led_if.G[0] & led_if.B[0]) == 1'b0) any_lo++;
      if (n % 10 == 9) begin
        chk($sformatf("frame%0d_on", n / 10), any_lo, exp_frame[n / 10]);
        if (n / 10 == 29) begin
          chk("duty3_red_R", r_lo, 3);
          chk("duty3_red_G", g_lo, 0);
          chk("duty3_red_B", b_lo, 0);
        end
        r_lo = 0; g_lo = 0; b_lo = 0; any_lo = 0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned pulses;
    led_if.button = 1'b1;
    // {edge n, colour after edge n, R, G, B after edge n}
    vecs[0]  = '{0,   3'd0, 4'hF, 4'hF, 4'hF};
    vecs[1]  = '{5,   3'd0, 4'hF, 4'hF, 4'hF};
    vecs[2]  = '{10,  3'd0, 4'h0, 4'hF, 4'hF};
    vecs[3]  = '{11,  3'd0, 4'hF, 4'hF, 4'hF};
    vecs[4]  = '{19,  3'd1, 4'hF, 4'hF, 4'hF};
    vecs[5]  = '{20,  3'd1, 4'hF, 4'h0, 4'hF};
    vecs[6]  = '{21,  3'd1, 4'hF, 4'h0, 4'hF};
    vecs[7]  = '{22,  3'd1, 4'hF, 4'hF, 4'hF};
    vecs[8]  = '{40,  3'd2, 4'hF, 4'hF, 4'h0};
    vecs[9]  = '{63,  3'd3, 4'hF, 4'h0, 4'h0};
    vecs[10] = '{86,  3'd4, 4'h0, 4'hF, 4'h0};
    vecs[11] = '{105, 3'd5, 4'h0, 4'h0, 4'hF};
    vecs[12] = '{125, 3'd6, 4'hF, 4'hF, 4'hF};
    vecs[13] = '{139, 3'd0, 4'hF, 4'hF, 4'hF};
    vecs[14] = '{140, 3'd0, 4'h0, 4'hF, 4'hF};
    vecs[15] = '{160, 3'd1, 4'hF, 4'hF, 4'hF};
    vecs[16] = '{170, 3'd1, 4'hF, 4'h0, 4'hF};
    // LED-on cycles per frame: duty envelope, zero while BLACK
    exp_frame = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 0, 0, 2,
                  1, 0, 1, 2, 3, 4, 5, 6, 7, 8, 7, 0, 0, 4, 3};

    do_reset();
    run_auto(300);

    // glitch, then a long press and release
    do_reset();
    pulses = 0;
    for (int unsigned n = 0; n <= 50; n++) begin
      led_if.button = !((n >= 2 && n < 4) || (n >= 20 && n < 32));
      tick();
      if (led_if.btn_evt) pulses++;
      if (n == 18) chk("deb_colour_n18", 32'(led_if.colour), 0);
      if (n == 19) begin
        chk("glitch_no_evt", pulses, 0);
        chk("deb_colour_n19", 32'(led_if.colour), 1);
      end
      if (n == 24) chk("press_evt_n24", 32'(led_if.btn_evt), 0);
      if (n == 25) begin
        chk("press_evt_n25", 32'(led_if.btn_evt), 1);
        chk("press_colour_n25", 32'(led_if.colour), 1);
      end
      if (n == 26) chk("press_colour_n26", 32'(led_if.colour), 2);
      if (n == 39) chk("hold_restart_n39", 32'(led_if.colour), 2);
      if (n == 45) chk("hold_restart_n45", 32'(led_if.colour), 2);
      if (n == 46) chk("hold_restart_n46", 32'(led_if.colour), 3);
    end
    chk("press_pulse_count", pulses, 1);

    // press accepted in the same cycle as the hold terminal count
    do_reset();
    pulses = 0;
    for (int unsigned n = 0; n <= 40; n++) begin
      led_if.button = !(n >= 13 && n < 25);
      tick();
      if (led_if.btn_evt) pulses++;
      if (n == 18) begin
        chk("coll_evt_n18", 32'(led_if.btn_evt), 1);
        chk("coll_colour_n18", 32'(led_if.colour), 0);
      end
      if (n == 19) chk("coll_colour_n19", 32'(led_if.colour), 1);
      if (n == 38) chk("coll_colour_n38", 32'(led_if.colour), 1);
      if (n == 39) chk("coll_colour_n39", 32'(led_if.colour), 2);
    end
    chk("coll_pulse_count", pulses, 1);

    // reset while YELLOW with duty 5
    do_reset();
    run_auto(112);
    chk_rgb("pre_midreset", 3'd5, 4'h0, 4'h0, 4'hF);
    rst = 1'b1;
    tick();
    chk_rgb("midreset", 3'd0, 4'hF, 4'hF, 4'hF);
    chk("midreset_btn_evt", 32'(led_if.btn_evt), 0);
    rst = 1'b0;
    run_auto(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
